mem_ctrl: RTL
=============

# mem_ctrl

Sequencing initiator for the LC-3 unified memory array. It accepts a single load/store request from the datapath, drives the memory's address/data/write-enable, and applies a configurable number of wait states. It samples read data, then reports completion with a one-cycle pulse. It sits between the control FSM and the `memory` array and is the only driver of that array's `MARReg`, `mdrOut` and `memWE`.

## Interface
- `WAIT_CYCLES`, default 1: number of wait states between address launch and the access cycle. Legal range 0..15.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  1: access request. Sampled only in IDLE.
- `we`  in  1: 1 = store, 0 = load. Sampled with `req`.
- `ind`  in  1: indirect access (LDI/STI style). Sampled with `req`; effective only under `MEM_CTRL_IND_EN`.
- `addr`  in  16: access address. Sampled with `req`.
- `wdata`  in  16: store data. Sampled with `req`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `rdata`  out  16: last load result. Held until the next load completes.
- `MARReg`  out  16: memory address, registered.
- `mdrOut`  out  16: memory write data, registered.
- `memWE`  out  1: memory write enable, registered.
- `memOut`  in  16: combinational read data from memory.

## Operation
- States:
  - IDLE, WAIT, ACCESS and DONE are always present.
  - PTR exists only with `MEM_CTRL_IND_EN`.
- IDLE:
  - On `req`=1, latch `addr`→`MARReg` and `wdata`→`mdrOut`.
  - Latch `we` and `ind` internally.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or go directly to ACCESS (or PTR when indirect) if `WAIT_CYCLES`=0.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is ACCESS, or PTR on the first phase of an indirect access.
- PTR:
  - Capture `memOut`→`MARReg`.
  - Reload the counter.
  - Go to WAIT, or to ACCESS if `WAIT_CYCLES`=0.
- ACCESS:
  - Store: `memWE`=1 for exactly this one cycle; the write lands at the ACCESS→DONE edge.
  - Load: `rdata`←`memOut` at the ACCESS→DONE edge.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
  - A `req` present during DONE is not accepted.
- `req` in any state other than IDLE is ignored. It is not queued.
- `MARReg` and `mdrOut` hold their values after completion, until the next accepted request.
- Reset:
  - Forces IDLE immediately.
  - All outputs return to their reset values.
  - An in-flight access is aborted; `memWE` drops asynchronously and no write occurs.

## Timing
- Reset values: `busy`=0, `done`=0, `memWE`=0, `rdata`=0x0000, `MARReg`=0x0000, `mdrOut`=0x0000.
- E0 is the edge that accepts `req`. W = `WAIT_CYCLES`.
- Direct access:
  - ACCESS is entered at edge E0+W.
  - DONE is entered at E0+W+1; `done` is high for the following cycle.
- Indirect access (macro on):
  - PTR is entered at E0+W.
  - ACCESS is entered at E0+2W+1.
  - DONE is entered at E0+2W+2.
- `req` held high continuously gives one access per W+3 cycles (direct).
- `MARReg` is stable from E0 through the end of ACCESS, so the combinational read is settled when it is sampled.

## Configuration
- `MEM_CTRL_IND_EN` defined:
  - The PTR state is present.
  - With `ind`=1, the first read fetches a pointer from `addr`.
  - The load or store then targets that pointer.
- `MEM_CTRL_IND_EN` undefined:
  - `ind` is ignored and treated as 0.
  - PTR is not synthesized.
  - All accesses are direct.

## Test plan
- Reset: assert `reset` mid-cycle -> all outputs at reset values immediately; `busy`=0 after release.
- Store then load, W=1:
  - Store 0xBEEF to 0x3000 -> `MARReg`=0x3000; `memWE` high exactly one cycle at E0+1; `done` at E0+2.
  - Load 0x3000 -> `rdata`=0xBEEF with the `done` pulse.
- Ignored request: pulse `req` (load 0x1111) while `busy`=1 -> no second access; `MARReg` unchanged.
- Back-to-back, W=0: hold `req`=1 for loads of 0x0010 and 0x0011 -> two `done` pulses 3 cycles apart, each with the correct `rdata`.
- Indirect load, W=1: mem[0x4000]=0x5000, mem[0x5000]=0x1234, load 0x4000 with `ind`=1.
  - Macro on -> `rdata`=0x1234, `done` at E0+4.
  - Macro off -> `rdata`=0x5000, `done` at E0+2.
- Abort: assert `reset` during WAIT of a store of 0xAAAA to 0x2000 -> `memWE` never high; mem[0x2000] unchanged.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response and memory-side bundle for mem_ctrl.
// slave = the controller; master = datapath plus memory array.
interface mem_ctrl_if;
   logic        req;
   logic        we;
   logic        ind;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
   logic [15:0] rdata;
   logic [15:0] MARReg;
   logic [15:0] mdrOut;
   logic        memWE;
   logic [15:0] memOut;

   modport slave  (input  req, we, ind, addr, wdata, memOut,
                   output busy, done, rdata, MARReg, mdrOut, memWE);
   modport master (output req, we, ind, addr, wdata, memOut,
                   input  busy, done, rdata, MARReg, mdrOut, memWE);
endinterface

// File: rtl/mem_ctrl.sv
// LC-3 memory sequencer: one load/store per request with WAIT_CYCLES wait states.
// Optional indirect (pointer-fetch) accesses are built when MEM_CTRL_IND_EN is defined.
module mem_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic         clk,
   input  logic         reset,
   mem_ctrl_if.slave    io_bus
);
   localparam logic [3:0] W = 4'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_DONE
`ifdef MEM_CTRL_IND_EN
      , S_PTR
`endif
   } state_t;

   state_t      r_state, w_next;
   state_t      w_idle_tgt, w_wait_tgt;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [15:0] r_mar, r_mdr, r_rdata;
   logic        r_memwe;
   logic        w_we_eff;
`ifdef MEM_CTRL_IND_EN
   logic        r_ind;
`endif

   // State reached once the wait states run out: the pointer fetch comes first on indirect requests
   always_comb begin
      w_idle_tgt = S_ACCESS;
      w_wait_tgt = S_ACCESS;
`ifdef MEM_CTRL_IND_EN
      if (io_bus.ind) w_idle_tgt = S_PTR;
      if (r_ind)      w_wait_tgt = S_PTR;
`endif
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (io_bus.req) w_next = (W == 4'd0) ? w_idle_tgt : S_WAIT;
         S_WAIT:   if (r_cnt <= 4'd1) w_next = w_wait_tgt;
`ifdef MEM_CTRL_IND_EN
         S_PTR:    w_next = (W == 4'd0) ? S_ACCESS : S_WAIT;
`endif
         S_ACCESS: w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // With W=0 ACCESS follows IDLE directly, before r_we has been latched
   assign w_we_eff = (r_state == S_IDLE) ? io_bus.we : r_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_mar   <= 16'h0000;
         r_mdr   <= 16'h0000;
         r_rdata <= 16'h0000;
         r_memwe <= 1'b0;
`ifdef MEM_CTRL_IND_EN
         r_ind   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_memwe <= (w_next == S_ACCESS) && w_we_eff;
         case (r_state)
            S_IDLE: if (io_bus.req) begin
               r_mar <= io_bus.addr;
               r_mdr <= io_bus.wdata;
               r_we  <= io_bus.we;
               r_cnt <= W;
`ifdef MEM_CTRL_IND_EN
               r_ind <= io_bus.ind;
`endif
            end
            S_WAIT: r_cnt <= r_cnt - 4'd1;
`ifdef MEM_CTRL_IND_EN
            S_PTR: begin
               r_mar <= io_bus.memOut;
               r_cnt <= W;
               r_ind <= 1'b0;
            end
`endif
            S_ACCESS: if (!r_we) r_rdata <= io_bus.memOut;
            default: ;
         endcase
      end
   end

   assign io_bus.busy   = (r_state != S_IDLE);
   assign io_bus.done   = (r_state == S_DONE);
   assign io_bus.rdata  = r_rdata;
   assign io_bus.MARReg = r_mar;
   assign io_bus.mdrOut = r_mdr;
   assign io_bus.memWE  = r_memwe;
endmodule
